am_align_ctrl: RTL and testbench
================================

// Module: am_align_ctrl
// PURPOSE
//  Top-level sequencer for the per-lane alignment-marker lock FSMs of the 100GbE PCS receive path.
//  - Waits for block lock on every lane, then enables the lane AM-lock FSMs.
//  - Supplies them with configured lock/unlock thresholds.
//  - Restarts lanes that fail to lock within a timeout.
//  - Reports global alignment status and counts per-lane AM resync events.
// PARAMETERS
//  N_LANES         20   number of PCS lanes / AM-lock FSM instances
//  NB_VALID_CNT    5    width of lock threshold (matches AM-lock FSM valid counter)
//  NB_INVALID_CNT  3    width of unlock threshold (matches AM-lock FSM invalid counter)
//  NB_TIMER        16   width of search timeout timer and i_cfg_timeout
//  NB_RESYNC_CNT   8    width of saturating resync event counter
//  DEF_LOCK_THR    3    reset value of o_lock_thr
//  DEF_UNLOCK_THR  5    reset value of o_unlock_thr
// PORTS
//  i_clock               in   1               system clock
//  i_reset               in   1               asynchronous, active-high reset
//  i_enable              in   1               controller enable; low forces IDLE
//  i_valid               in   1               block valid strobe; timer advances only when high
//  i_block_lock          in   N_LANES         per-lane block lock
//  i_am_lock             in   N_LANES         per-lane AM lock from AM-lock FSMs
//  i_resync_by_am_start  in   N_LANES         per-lane resync pulse from AM-lock FSMs
//  i_cfg_load            in   1               load pulse for the cfg inputs below
//  i_cfg_lock_thr        in   NB_VALID_CNT    new lock threshold
//  i_cfg_unlock_thr      in   NB_INVALID_CNT  new unlock threshold
//  i_cfg_timeout         in   NB_TIMER        search timeout in valid blocks; 0 disables timeout
//  o_lock_thr            out  NB_VALID_CNT    threshold driven to all AM-lock FSMs
//  o_unlock_thr          out  NB_INVALID_CNT  threshold driven to all AM-lock FSMs
//  o_lane_enable         out  N_LANES         per-lane AM-lock FSM enable
//  o_lane_restart        out  N_LANES         one-cycle per-lane restart pulse
//  o_align_status        out  1               all lanes AM-locked
//  o_cfg_err             out  1               one-cycle pulse: cfg load rejected
//  o_resync_cnt          out  NB_RESYNC_CNT   saturating count of resync pulses
//  o_state               out  2               IDLE=0 WAIT_BLK=1 SEARCH=2 ALIGNED=3
// BEHAVIOUR
//  Reset values and latency
//  - Reset values: o_state=IDLE, o_lane_enable=0, o_lane_restart=0, o_align_status=0, o_cfg_err=0,
//    o_resync_cnt=0, o_lock_thr=DEF_LOCK_THR, o_unlock_thr=DEF_UNLOCK_THR, timer=0.
//  - All outputs are registered: one-cycle latency from the causing input.
//  State machine
//  - i_enable=0 in any state: next state IDLE, enables cleared, timer cleared. This has priority over every transition below.
//  - IDLE: i_enable=1 -> WAIT_BLK.
//  - WAIT_BLK:
//    - o_lane_enable=0.
//    - &i_block_lock=1 -> SEARCH; o_lane_enable set to all ones and timer cleared in the same edge.
//  - SEARCH:
//    - Timer increments when i_valid=1.
//    - &i_am_lock=1 -> ALIGNED.
//    - Any i_block_lock bit low -> WAIT_BLK. This beats the other SEARCH transitions.
//    - Timer reaching i_cfg_timeout (timeout !=0) while not all lanes locked:
//      o_lane_restart = ~i_am_lock for one cycle, timer cleared, stay SEARCH.
//    - Timer saturates when timeout=0.
//  - ALIGNED:
//    - o_align_status=1.
//    - Any i_block_lock low -> WAIT_BLK.
//    - Else any i_am_lock low -> SEARCH with timer cleared.
//    - o_align_status drops in the same edge as the transition.
//  Resync counting
//  - o_resync_cnt += popcount(i_resync_by_am_start) each cycle, in any state except IDLE.
//  - Saturates at all ones and never wraps.
//  - Cleared only by reset.
//  Configuration
//  - i_cfg_load is accepted only in IDLE or WAIT_BLK.
//  - A load in SEARCH or ALIGNED is ignored and pulses o_cfg_err.
//  - i_cfg_lock_thr=0 is clamped to 1; i_cfg_unlock_thr=0 is clamped to 1.
//  - i_cfg_timeout is sampled continuously; it is not latched.
//  - A cfg load coincident with a state change is judged against the current (pre-edge) state.
//  Reset mid-operation
//  - Asynchronous reset returns every output to its reset value immediately.
// TESTING
//  1. Reset, i_enable=1, i_block_lock=all ones at cycle 5, i_am_lock=all ones 30 cycles later
//     -> state 0->1->2->3, o_lane_enable=all ones, o_align_status=1 one cycle after am_lock.
//  2. In SEARCH, i_cfg_timeout=50, i_valid=1, lanes 0..18 locked, lane 19 not
//     -> after 50 cycles o_lane_restart=20'h80000 for exactly one cycle, timer restarts.
//  3. In ALIGNED, drop i_am_lock[7] -> SEARCH, o_align_status=0 next edge.
//     Then drop i_block_lock[3] -> WAIT_BLK, o_lane_enable=0.
//  4. i_cfg_load with lock_thr=0, unlock_thr=4 in WAIT_BLK -> o_lock_thr=1, o_unlock_thr=4.
//     Same load in ALIGNED -> thresholds unchanged, o_cfg_err pulses once.
//  5. Pulse i_resync_by_am_start=20'h00005 300 times -> o_resync_cnt saturates at 255.
//  6. Assert i_reset asynchronously mid-SEARCH -> all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/am_align_ctrl_if.sv
// Control and status bundle of the AM alignment sequencer. The slave modport is the
// sequencer side; the master modport is whatever drives lock status and configuration.
interface am_align_ctrl_if #(
  parameter int N_LANES        = 20,
  parameter int NB_VALID_CNT   = 5,
  parameter int NB_INVALID_CNT = 3,
  parameter int NB_TIMER       = 16,
  parameter int NB_RESYNC_CNT  = 8
);
  logic                      i_enable;
  logic                      i_valid;
  logic [N_LANES-1:0]        i_block_lock;
  logic [N_LANES-1:0]        i_am_lock;
  logic [N_LANES-1:0]        i_resync_by_am_start;
  logic                      i_cfg_load;
  logic [NB_VALID_CNT-1:0]   i_cfg_lock_thr;
  logic [NB_INVALID_CNT-1:0] i_cfg_unlock_thr;
  logic [NB_TIMER-1:0]       i_cfg_timeout;
  logic [NB_VALID_CNT-1:0]   o_lock_thr;
  logic [NB_INVALID_CNT-1:0] o_unlock_thr;
  logic [N_LANES-1:0]        o_lane_enable;
  logic [N_LANES-1:0]        o_lane_restart;
  logic                      o_align_status;
  logic                      o_cfg_err;
  logic [NB_RESYNC_CNT-1:0]  o_resync_cnt;
  logic [1:0]                o_state;

  modport slave (
    input  i_enable, i_valid, i_block_lock, i_am_lock, i_resync_by_am_start,
           i_cfg_load, i_cfg_lock_thr, i_cfg_unlock_thr, i_cfg_timeout,
    output o_lock_thr, o_unlock_thr, o_lane_enable, o_lane_restart,
           o_align_status, o_cfg_err, o_resync_cnt, o_state
  );

  modport master (
    output i_enable, i_valid, i_block_lock, i_am_lock, i_resync_by_am_start,
           i_cfg_load, i_cfg_lock_thr, i_cfg_unlock_thr, i_cfg_timeout,
    input  o_lock_thr, o_unlock_thr, o_lane_enable, o_lane_restart,
           o_align_status, o_cfg_err, o_resync_cnt, o_state
  );
endinterface

// File: rtl/am_align_ctrl.sv
// Sequencer for the per-lane AM-lock FSMs of the 100GbE PCS receive path: gates lane
// enables on block lock, restarts stuck lanes on timeout, counts resyncs, holds thresholds.
module am_align_ctrl #(
  parameter int N_LANES        = 20,
  parameter int NB_VALID_CNT   = 5,
  parameter int NB_INVALID_CNT = 3,
  parameter int NB_TIMER       = 16,
  parameter int NB_RESYNC_CNT  = 8,
  parameter int DEF_LOCK_THR   = 3,
  parameter int DEF_UNLOCK_THR = 5
) (
  input  logic          i_clock,
  input  logic          i_reset,
  am_align_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BLK = 2'd1,
    ST_SEARCH   = 2'd2,
    ST_ALIGNED  = 2'd3
  } state_e;

  localparam int                  NB_POP    = $clog2(N_LANES + 1);
  localparam int                  NB_SUM    = NB_RESYNC_CNT + 1;
  localparam logic [NB_TIMER-1:0] TIMER_MAX = '1;

  state_e                    state_q;
  logic [NB_TIMER-1:0]       timer_q;
  logic [N_LANES-1:0]        lane_enable_q;
  logic [N_LANES-1:0]        lane_restart_q;
  logic                      align_status_q;
  logic                      cfg_err_q, cfg_err_d;
  logic [NB_RESYNC_CNT-1:0]  resync_cnt_q, resync_cnt_d;
  logic [NB_VALID_CNT-1:0]   lock_thr_q, lock_thr_d;
  logic [NB_INVALID_CNT-1:0] unlock_thr_q, unlock_thr_d;

  logic                      all_blk_lock;
  logic                      all_am_lock;
  logic                      timeout_hit;
  logic [NB_TIMER:0]         timer_inc;
  logic [NB_TIMER-1:0]       timer_adv;
  logic [NB_SUM-1:0]         resync_sum;

  function automatic logic [NB_POP-1:0] popcount(input logic [N_LANES-1:0] v);
    logic [NB_POP-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_LANES; i++) cnt = cnt + NB_POP'(v[i]);
    return cnt;
  endfunction

  assign all_blk_lock = &bus.i_block_lock;
  assign all_am_lock  = &bus.i_am_lock;

  // The timeout fires on the valid block that brings the count up to the configured value;
  // with timeout disabled the timer just saturates.
  assign timer_inc   = {1'b0, timer_q} + NB_SUM'(0) + (NB_TIMER + 1)'(bus.i_valid);
  assign timeout_hit = (bus.i_cfg_timeout != '0) && (timer_inc >= {1'b0, bus.i_cfg_timeout});
  assign timer_adv   = (timer_q == TIMER_MAX) ? timer_q : timer_inc[NB_TIMER-1:0];

  assign resync_sum = {1'b0, resync_cnt_q} + NB_SUM'(popcount(bus.i_resync_by_am_start));

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    lock_thr_d   = lock_thr_q;
    unlock_thr_d = unlock_thr_q;
    cfg_err_d    = 1'b0;
    resync_cnt_d = resync_cnt_q;

    if (bus.i_cfg_load) begin
      if (state_q == ST_IDLE || state_q == ST_WAIT_BLK) begin
        lock_thr_d   = (bus.i_cfg_lock_thr == '0) ? NB_VALID_CNT'(1) : bus.i_cfg_lock_thr;
        unlock_thr_d = (bus.i_cfg_unlock_thr == '0) ? NB_INVALID_CNT'(1) : bus.i_cfg_unlock_thr;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (state_q != ST_IDLE) begin
      resync_cnt_d = resync_sum[NB_RESYNC_CNT] ? '1 : resync_sum[NB_RESYNC_CNT-1:0];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      lock_thr_q   <= NB_VALID_CNT'(DEF_LOCK_THR);
      unlock_thr_q <= NB_INVALID_CNT'(DEF_UNLOCK_THR);
      cfg_err_q    <= 1'b0;
      resync_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      lock_thr_q   <= lock_thr_d;
      unlock_thr_q <= unlock_thr_d;
      cfg_err_q    <= cfg_err_d;
      resync_cnt_q <= resync_cnt_d;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      lane_enable_q  <= '0;
      lane_restart_q <= '0;
      align_status_q <= 1'b0;
    end else begin
      lane_restart_q <= '0;
      if (!bus.i_enable) begin
        state_q        <= ST_IDLE;
        timer_q        <= '0;
        lane_enable_q  <= '0;
        align_status_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            lane_enable_q  <= '0;
            align_status_q <= 1'b0;
            state_q        <= ST_WAIT_BLK;
          end
          ST_WAIT_BLK: begin
            lane_enable_q  <= '0;
            align_status_q <= 1'b0;
            if (all_blk_lock) begin
              state_q       <= ST_SEARCH;
              lane_enable_q <= '1;
              timer_q       <= '0;
            end
          end
          ST_SEARCH: begin
            // Losing block lock outranks both lock completion and timeout restarts.
            if (!all_blk_lock) begin
              state_q       <= ST_WAIT_BLK;
              lane_enable_q <= '0;
            end else if (all_am_lock) begin
              state_q        <= ST_ALIGNED;
              align_status_q <= 1'b1;
            end else if (timeout_hit) begin
              lane_restart_q <= ~bus.i_am_lock;
              timer_q        <= '0;
            end else begin
              timer_q <= timer_adv;
            end
          end
          ST_ALIGNED: begin
            if (!all_blk_lock) begin
              state_q        <= ST_WAIT_BLK;
              lane_enable_q  <= '0;
              align_status_q <= 1'b0;
            end else if (!all_am_lock) begin
              state_q        <= ST_SEARCH;
              timer_q        <= '0;
              align_status_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_state        = state_q;
  assign bus.o_lane_enable  = lane_enable_q;
  assign bus.o_lane_restart = lane_restart_q;
  assign bus.o_align_status = align_status_q;
  assign bus.o_cfg_err      = cfg_err_q;
  assign bus.o_resync_cnt   = resync_cnt_q;
  assign bus.o_lock_thr     = lock_thr_q;
  assign bus.o_unlock_thr   = unlock_thr_q;

endmodule

// File: tb/tb_am_align_ctrl.sv
// Bench for am_align_ctrl: a vector table for the state/config corners, then hand-built
// sequences for lock-up, timeout restart, resync saturation and asynchronous reset.
module tb_am_align_ctrl;
  localparam int          N   = 20;
  localparam logic [N-1:0] ALL = '1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  am_align_ctrl_if #(.N_LANES(N)) bus ();
  am_align_ctrl #(.N_LANES(N)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));

  typedef struct {
    logic en, valid, load;
    logic [N-1:0] blk, am, rs;
    logic [4:0] lthr;
    logic [2:0] uthr;
    logic [15:0] tmo;
  } in_t;

  typedef struct {
    logic [1:0] st;
    logic [N-1:0] len, rstrt;
    logic align, err;
    logic [4:0] lthr;
    logic [2:0] uthr;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t d);
    bus.i_enable             = d.en;
    bus.i_valid              = d.valid;
    bus.i_cfg_load           = d.load;
    bus.i_block_lock         = d.blk;
    bus.i_am_lock            = d.am;
    bus.i_resync_by_am_start = d.rs;
    bus.i_cfg_lock_thr       = d.lthr;
    bus.i_cfg_unlock_thr     = d.uthr;
    bus.i_cfg_timeout        = d.tmo;
  endtask

  task automatic compare_out(input exp_t e, input string tag);
    check($sformatf("%s.state", tag),   32'(bus.o_state),        32'(e.st));
    check($sformatf("%s.lane_en", tag), 32'(bus.o_lane_enable),  32'(e.len));
    check($sformatf("%s.restart", tag), 32'(bus.o_lane_restart), 32'(e.rstrt));
    check($sformatf("%s.align", tag),   32'(bus.o_align_status), 32'(e.align));
    check($sformatf("%s.cfg_err", tag), 32'(bus.o_cfg_err),      32'(e.err));
    check($sformatf("%s.lock_thr", tag),   32'(bus.o_lock_thr),   32'(e.lthr));
    check($sformatf("%s.unlock_thr", tag), 32'(bus.o_unlock_thr), 32'(e.uthr));
    check($sformatf("%s.resync", tag),  32'(bus.o_resync_cnt),   32'(e.cnt));
  endtask

  // Drive one cycle of stimulus, queue its expectation, and compare after the edge.
  task automatic apply(input in_t d, input exp_t e, input string tag);
    exp_t got;
    drive(d);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    compare_out(got, tag);
  endtask

  task automatic add_vec(input logic en, input logic load, input logic [N-1:0] blk,
                         input logic [N-1:0] am, input logic [N-1:0] rs,
                         input logic [4:0] lthr, input logic [2:0] uthr,
                         input logic [1:0] est, input logic [N-1:0] elen,
                         input logic ealign, input logic eerr, input logic [4:0] elthr,
                         input logic [2:0] euthr, input logic [7:0] ecnt);
    vec_t v;
    v.i = '{en: en, valid: 1'b0, load: load, blk: blk, am: am, rs: rs,
            lthr: lthr, uthr: uthr, tmo: 16'd0};
    v.e = '{st: est, len: elen, rstrt: '0, align: ealign, err: eerr,
            lthr: elthr, uthr: euthr, cnt: ecnt};
    vecs.push_back(v);
  endtask

  in_t  d;
  exp_t x;
  int   tmp;

  initial begin
    rst = 1'b1;
    d = '{en: 1'b0, valid: 1'b0, load: 1'b0, blk: '0, am: '0, rs: '0,
          lthr: 5'd0, uthr: 3'd0, tmo: 16'd0};
    drive(d);
    x = '{st: 2'd0, len: '0, rstrt: '0, align: 1'b0, err: 1'b0,
          lthr: 5'd3, uthr: 3'd5, cnt: 8'd0};
    #12;
    compare_out(x, "reset");
    @(negedge clk);
    rst = 1'b0;

    //       en load blk             am              rs      lthr uthr | st len align err lthr uthr cnt
    add_vec(0, 0, '0,             '0,             '0,     0, 0,   0, '0,  0, 0, 3, 5, 0);
    add_vec(1, 1, '0,             '0,             '0,     0, 4,   1, '0,  0, 0, 1, 4, 0);
    add_vec(1, 0, '0,             '0,             20'h5,  0, 0,   1, '0,  0, 0, 1, 4, 2);
    add_vec(1, 0, ALL,            '0,             '0,     0, 0,   2, ALL, 0, 0, 1, 4, 2);
    add_vec(1, 1, ALL,            '0,             '0,     7, 2,   2, ALL, 0, 1, 1, 4, 2);
    add_vec(1, 0, ALL,            ALL,            '0,     0, 0,   3, ALL, 1, 0, 1, 4, 2);
    add_vec(1, 1, ALL,            ALL,            '0,     0, 4,   3, ALL, 1, 1, 1, 4, 2);
    add_vec(1, 0, ALL,            20'hFFF7F,      '0,     0, 0,   2, ALL, 0, 0, 1, 4, 2);
    add_vec(1, 0, ALL,            ALL,            '0,     0, 0,   3, ALL, 1, 0, 1, 4, 2);
    add_vec(1, 0, 20'hFFFF7,      ALL,            '0,     0, 0,   1, '0,  0, 0, 1, 4, 2);
    add_vec(1, 1, ALL,            ALL,            '0,     9, 0,   2, ALL, 0, 0, 9, 1, 2);
    add_vec(0, 0, ALL,            ALL,            '0,     0, 0,   0, '0,  0, 0, 9, 1, 2);
    add_vec(0, 1, '0,             '0,             ALL,    6, 7,   0, '0,  0, 0, 6, 7, 2);

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));

    // Lock-up: block lock after a few cycles, AM lock 30 cycles later.
    d = '{en: 1'b1, valid: 1'b0, load: 1'b0, blk: '0, am: '0, rs: '0,
          lthr: 5'd0, uthr: 3'd0, tmo: 16'd0};
    x = '{st: 2'd1, len: '0, rstrt: '0, align: 1'b0, err: 1'b0,
          lthr: 5'd6, uthr: 3'd7, cnt: 8'd2};
    for (int k = 0; k < 5; k++) apply(d, x, $sformatf("wait_blk%0d", k));
    d.blk = ALL;
    x.st  = 2'd2;
    x.len = ALL;
    for (int k = 0; k < 30; k++) apply(d, x, $sformatf("search%0d", k));
    d.am    = ALL;
    x.st    = 2'd3;
    x.align = 1'b1;
    apply(d, x, "aligned");

    // Lane 19 never locks: a restart pulse every 50 valid blocks.
    d.am    = 20'h7FFFF;
    d.tmo   = 16'd50;
    d.valid = 1'b1;
    x.st    = 2'd2;
    x.align = 1'b0;
    apply(d, x, "to_search");
    for (int k = 1; k <= 100; k++) begin
      x.rstrt = (k % 50 == 0) ? 20'h80000 : '0;
      apply(d, x, $sformatf("timeout%0d", k));
    end

    // Resync counting saturates and holds.
    d.tmo   = 16'd0;
    d.valid = 1'b0;
    d.rs    = 20'h00005;
    x.rstrt = '0;
    for (int k = 0; k < 300; k++) begin
      tmp   = int'(x.cnt) + 2;
      x.cnt = (tmp > 255) ? 8'd255 : 8'(tmp);
      apply(d, x, $sformatf("resync%0d", k));
    end
    check("resync_final", 32'(bus.o_resync_cnt), 32'd255);

    // Asynchronous reset between clock edges in SEARCH.
    d.rs = '0;
    drive(d);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    x = '{st: 2'd0, len: '0, rstrt: '0, align: 1'b0, err: 1'b0,
          lthr: 5'd3, uthr: 3'd5, cnt: 8'd0};
    compare_out(x, "async_reset");
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
